// File: rtl/mem_writer_pkg.sv
// Shared types and defaults for the burst-loaded lookup table (mem_writer).
package mem_writer_pkg;

    localparam int unsigned DEF_DATA_W = 4;
    localparam int unsigned DEF_ADDR_W = 3;
    localparam int unsigned DEF_DEPTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Power-on/reset table contents: entry i holds 2*i, wrapped to the word width.
    function automatic int unsigned default_word(input int unsigned i,
                                                 input int unsigned dw = DEF_DATA_W);
        return (2 * i) % (32'd1 << dw);
    endfunction

endpackage

// File: rtl/mem_writer_array.sv
// Table storage for mem_writer: reset-initialised registers, one write port,
// combinational read mux.
module mem_writer_array
    import mem_writer_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DATA_W'(default_word(i, DATA_W));
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_writer.sv
// Burst writer for the 8x4 lookup table: command (addr, len) then beats on wr_valid/wr_ready.
// Optional MEM_WRITER_WRAP_ERR_EN rejects bursts that would run past the last entry.
module mem_writer
    import mem_writer_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_done;
    logic              r_err;

    logic              w_cmd_fire;
    logic              w_beat_fire;
    logic              w_cmd_oob;

    assign cmd_ready   = (r_state == ST_IDLE);
    assign wr_ready    = (r_state == ST_BURST);
    assign busy        = (r_state == ST_BURST) || (r_state == ST_DONE);
    assign done        = r_done;
    assign err         = r_err;

    assign w_cmd_fire  = cmd_valid && cmd_ready;
    assign w_beat_fire = wr_valid && wr_ready;

`ifdef MEM_WRITER_WRAP_ERR_EN
    logic [ADDR_W+1:0] w_end;
    // Two spare bits so addr+len never overflows before the compare.
    assign w_end     = {2'b00, cmd_addr} + {1'b0, cmd_len};
    assign w_cmd_oob = (w_end > (ADDR_W+2)'(DEPTH));
`else
    assign w_cmd_oob = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_fire) begin
                        r_err <= w_cmd_oob;
                        if (w_cmd_oob || (cmd_len == '0)) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_ptr       <= cmd_addr;
                            r_remaining <= cmd_len;
                            r_state     <= ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    if (w_beat_fire) begin
                        // ptr is exactly ADDR_W bits wide, so it wraps modulo DEPTH for free.
                        r_ptr       <= r_ptr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == (ADDR_W+1)'(1)) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    mem_writer_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_beat_fire),
        .i_waddr (r_ptr),
        .i_wdata (wr_data),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

endmodule

// File: doc/mem_writer.md
Name: mem_writer

Overview:
- Write-side companion to the team's small lookup memory.
- Owns an 8-entry x 4-bit storage array and loads it through burst write commands: start address plus length, then data beats on a valid/ready handshake, with address auto-increment.
- Keeps an asynchronous combinational read port so downstream logic reads the table exactly as it reads the fixed lookup memory today.
- Sits between a configuration/host sequencer and table consumers.

Parameters:
- DATA_W, 4, width of each stored word.
- ADDR_W, 3, address width.
- DEPTH, 8, number of entries; must equal 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- cmd_valid  input  1  burst command present.
- cmd_ready  output  1  block accepts a command; high only in IDLE.
- cmd_addr  input  ADDR_W  burst start address.
- cmd_len  input  ADDR_W+1  beat count, 0..DEPTH.
- wr_valid  input  1  write data beat present.
- wr_ready  output  1  block accepts a beat; high only in BURST.
- wr_data  input  DATA_W  write data.
- busy  output  1  high in BURST and DONE.
- done  output  1  one-cycle pulse when a command completes.
- err  output  1  sticky error flag; tied 0 unless WRAP_ERR_EN is defined.
- rd_addr  input  ADDR_W  read address.
- rd_data  output  DATA_W  mem[rd_addr], combinational.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled on the rising edge of clk.
- Reset state:
  - state = IDLE.
  - mem[i] = (2*i) mod 2**DATA_W, giving 0,2,4,...,14 at defaults.
  - ptr = 0, remaining = 0.
  - done = 0, err = 0, busy = 0, wr_ready = 0, cmd_ready = 1 from the first post-reset cycle.
- States: IDLE, BURST, DONE. cmd_ready, wr_ready and busy are decoded from state; done and err are registered.
- IDLE:
  - On cmd_valid && cmd_ready with cmd_len == 0: next state DONE, no writes.
  - Otherwise: ptr <= cmd_addr, remaining <= cmd_len, next state BURST.
- BURST:
  - Each wr_valid && wr_ready edge: mem[ptr] <= wr_data; ptr <= (ptr+1) mod DEPTH; remaining <= remaining-1.
  - The beat accepted with remaining == 1 moves the block to DONE.
  - wr_valid low means no state change (stall is unbounded).
- DONE: done = 1 for exactly one cycle, then IDLE. cmd_ready returns high the cycle after the done pulse.
- Latency:
  - Command accept to wr_ready high: 1 cycle.
  - Last beat to done: done is high in the cycle after the last accepted beat.
  - Throughput: 1 beat per cycle.
- Read port:
  - rd_data is purely combinational from mem.
  - A write to rd_addr becomes visible on rd_data the cycle after the write edge; the same cycle shows the old value.
- Input gating: cmd_* inputs are ignored outside IDLE; wr_* inputs are ignored outside BURST.
- Wrap-around: without WRAP_ERR_EN, a burst running past DEPTH-1 continues at 0. A len = DEPTH burst rewrites every entry once.
- Reset mid-burst: the burst is aborted, the table is reloaded with defaults, and there is no done pulse.

Optional Feature:
- Macro: MEM_WRITER_WRAP_ERR_EN.
- Defined:
  - On command accept, if cmd_addr + cmd_len > DEPTH (computed at ADDR_W+2 bits), the command is accepted but no beats are taken.
  - Next state is DONE with done pulsed; err is set and held.
  - err clears on the next accepted in-range command.
- Not defined: address wraps modulo DEPTH and err is constant 0.

Decomposition:
- Package mem_writer_pkg:
  - state encoding constants for IDLE, BURST, DONE.
  - default DATA_W, ADDR_W, DEPTH.
  - function default_word(i) returning (2*i) mod 2**DATA_W.
- Sub-module mem_writer_array: storage registers, synchronous reset init from default_word, single write port, combinational read mux.
- mem_writer top: FSM, ptr/remaining counters, handshake, error logic.

Test Plan:
- Reset then read all addresses 0..7 -> rd_data = 0,2,4,6,8,10,12,14; cmd_ready = 1, busy = 0, done = 0.
- Command addr=2 len=3, beats 0xA, 0xB, 0xC back-to-back -> mem[2..4] = A,B,C, other entries unchanged, done pulses 1 cycle after 0xC, cmd_ready high the following cycle.
- Command addr=6 len=4, wr_valid toggled 1,0,1,0,...; beats 1,2,3,4 -> without macro mem[6]=1, mem[7]=2, mem[0]=3, mem[1]=4; with macro no writes, err = 1, done pulses.
- cmd_len = 0 -> done pulses the cycle after accept, no mem change, wr_ready never asserted; a cmd_valid pulse during BURST is ignored.
- Command addr=0 len=8, assert rst after 3 beats -> table back to defaults next cycle, state IDLE, no done pulse.
- Write 0xF to addr 5 with rd_addr=5 -> rd_data = 10 in the write cycle and 15 the cycle after.
